// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the instruction fetch unit
package ifetch_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_MEM_SIZE = 32'h0000_8000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer; ports clk, rst_n, push/push_entry, pop, flush, count, head (zero when empty)
module fetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(push);
      r_rd    <= r_rd + AW'(pop);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) r_mem[r_wr] <= push_entry;
  assign count = r_count;
  assign head  = r_count != '0 ? r_mem[r_rd] : '0;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, in-flight tracking and RUN/FAULT control around a prefetch FIFO.
// Ports: clk, rst_n (async active low), imem_address/imem_instruction (memory, 1-edge latency),
// redirect_valid/redirect_pc, inst_valid/inst_ready/inst_data/inst_pc (consumer), fetch_fault.
// Optional: FETCH_PERF_EN adds fetch_count, a free-running count of consumer pops.
module instr_fetch import ifetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t r_state, w_next_state;
  logic [31:0] r_addr, r_inflight_pc;
  logic r_inflight_valid;
  logic [CW-1:0] w_count;
  fetch_entry_t w_head;
  logic w_bad, w_try, w_issue, w_fault_go, w_push, w_pop;
  // in-flight word counts against capacity so a push can never overflow
  assign w_try      = r_state == RUN && !redirect_valid &&
                      (w_count + CW'(r_inflight_valid)) < CW'(FIFO_DEPTH);
  assign w_bad      = r_addr > MEM_SIZE - 32'd4 || r_addr[1:0] != 2'b00;
  assign w_issue    = w_try && !w_bad;
  assign w_fault_go = w_try && w_bad;
  assign w_push     = r_inflight_valid && !redirect_valid;
  assign w_pop      = inst_valid && inst_ready && !redirect_valid;
  always_comb begin
    w_next_state = r_state;
    w_next_state = redirect_valid ? RUN : w_fault_go ? FAULT : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr           <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
    end else begin
      r_inflight_valid <= w_issue;
      if (redirect_valid) r_addr <= redirect_pc;
      else if (w_issue) begin
        r_inflight_pc <= r_addr;
        r_addr        <= r_addr + 32'd4;
      end
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .push_entry ('{pc: r_inflight_pc, instr: imem_instruction}),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .count      (w_count),
    .head       (w_head)
  );
  assign imem_address = r_addr;
  assign inst_valid   = w_count != '0;
  assign inst_data    = w_head.instr;
  assign inst_pc      = w_head.pc;
  assign fetch_fault  = r_state == FAULT;
`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     r_fetch_count <= '0;
    else if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
  assign fetch_count = r_fetch_count;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed scoreboard bench for instr_fetch
module tb_instr_fetch;
  import ifetch_pkg::*;
  localparam logic [31:0] MEM_SIZE = 32'h8000;
  logic clk = 0, rst_n = 0;
  logic [31:0] imem_address, imem_instruction = '0;
  logic redirect_valid = 0, inst_ready = 1;
  logic [31:0] redirect_pc = '0;
  logic inst_valid, fetch_fault;
  logic [31:0] inst_data, inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif
  int pass_cnt = 0, total_cnt = 0, pops_seen = 0;
  fetch_entry_t exp_q[$];
  instr_fetch #(.RESET_PC(32'h0), .MEM_SIZE(MEM_SIZE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_address(imem_address), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction
  always @(posedge clk) imem_instruction <= mem_word(imem_address);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // the delivered stream after a restart at p: consecutive words until the first illegal address
  task automatic load_expected(input logic [31:0] p);
    logic [31:0] a;
    exp_q.delete();
    a = p;
    while (a[1:0] == 2'b00 && a <= MEM_SIZE - 32'd4) begin
      exp_q.push_back('{pc: a, instr: mem_word(a)});
      a += 32'd4;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [31:0] p);
    redirect_valid = 1;
    redirect_pc = p;
    load_expected(p);
    step();
    redirect_valid = 0;
  endtask
  logic s_valid = 0;
  logic [31:0] s_pc, s_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_valid = 0;
      pops_seen = 0;
    end else begin
      if (s_valid) begin
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_pc", inst_pc, s_pc);
        chk("stall_data", inst_data, s_data);
      end
      s_valid = inst_valid && !inst_ready && !redirect_valid;
      s_pc = inst_pc;
      s_data = inst_data;
      if (inst_valid && inst_ready && !redirect_valid) begin
        pops_seen++;
        if (exp_q.size() == 0) chk("unexpected_pop_pc", inst_pc, 32'hxxxx_xxxx);
        else begin
          chk("pop_pc", inst_pc, exp_q[0].pc);
          chk("pop_data", inst_data, exp_q[0].instr);
          void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    int lat;
    logic [31:0] p;
    repeat (3) step();
    chk("rst_addr", imem_address, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    load_expected(32'h0);
    rst_n = 1;
    lat = 0;
    while (!inst_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("first_latency", lat, 2);
    chk("first_pc0", inst_pc, 32'h0);
    step();
    chk("first_pc4", inst_pc, 32'h4);
    step();
    chk("first_pc8", inst_pc, 32'h8);
    inst_ready = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
    end
    chk("hold_no_issue", imem_address, inst_pc + 32'd16);
    inst_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("release_no_gap", {31'b0, inst_valid}, 32'd1);
    end
    rst_n = 0;
    inst_ready = 0;
    #2;
    chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_addr", imem_address, 32'h0);
`ifdef FETCH_PERF_EN
    chk("midrst_perf", fetch_count, 32'd0);
`endif
    step();
    load_expected(32'h0);
    rst_n = 1;
    repeat (4) step();
    chk("fill_addr", imem_address, 32'h10);
    redirect(32'h100);
    chk("redir_flush0", {31'b0, inst_valid}, 32'd0);
    inst_ready = 1;
    step();
    chk("redir_flush1", {31'b0, inst_valid}, 32'd0);
    step();
    chk("redir_valid", {31'b0, inst_valid}, 32'd1);
    chk("redir_pc", inst_pc, 32'h100);
    redirect(32'h7FE0);
    repeat (20) step();
    chk("top_drained", exp_q.size(), 0);
    chk("top_fault", {31'b0, fetch_fault}, 32'd1);
    chk("top_valid", {31'b0, inst_valid}, 32'd0);
    chk("top_addr", imem_address, 32'h8000);
    redirect(32'h0);
    chk("clear_fault", {31'b0, fetch_fault}, 32'd0);
    step();
    chk("resume_lat1", {31'b0, inst_valid}, 32'd0);
    step();
    chk("resume_valid", {31'b0, inst_valid}, 32'd1);
    redirect(32'h102);
    repeat (6) step();
    chk("misalign_fault", {31'b0, fetch_fault}, 32'd1);
    chk("misalign_valid", {31'b0, inst_valid}, 32'd0);
    chk("misalign_none", exp_q.size(), 0);
    redirect(32'h200);
    for (int i = 0; i < 1500; i++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: p = {17'b0, 13'($urandom_range(0, 32'h1FFF)), 2'b00};
          1: p = MEM_SIZE - 32'd4 * 32'($urandom_range(1, 12));
          2: p = {17'b0, 13'($urandom_range(0, 32'h1FFF)), 2'($urandom_range(1, 3))};
          default: p = 32'h0;
        endcase
        redirect(p);
      end else step();
    end
`ifdef FETCH_PERF_EN
    inst_ready = 0;
    step();
    chk("perf_count", fetch_count, 32'(pops_seen));
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter MEM_SIZE, default 32'h8000, is the instruction memory size in bytes.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2, is the prefetch buffer entries.
REQ-004 clk  in  1  single clock, all state on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_address  out  32  fetch byte address, registered.
REQ-007 imem_instruction  in  32  memory word; valid one clock edge after imem_address is sampled.
REQ-008 redirect_valid  in  1  one-cycle request to restart fetch.
REQ-009 redirect_pc  in  32  new fetch address, qualified by redirect_valid.
REQ-010 inst_valid  out  1  FIFO head valid.
REQ-011 inst_ready  in  1  consumer accepts head.
REQ-012 inst_data  out  32  instruction at head.
REQ-013 inst_pc  out  32  address of inst_data.
REQ-014 fetch_fault  out  1  sticky: fetch stopped on a bad address.

Function
REQ-015 The memory has no enable and samples imem_address every edge; an issue is an edge where the block marks that sample as in-flight (inflight_valid<=1, inflight_pc<=imem_address, imem_address<=imem_address+4).
REQ-016 An issue occurs only in state RUN when count+inflight_valid < FIFO_DEPTH, ignoring same-cycle pop.
REQ-017 At the edge after an issue, {inflight_pc, imem_instruction} is pushed to the FIFO unless squashed.
REQ-018 Handshake: a pop occurs on an edge with inst_valid && inst_ready; inst_data and inst_pc hold stable while inst_valid && !inst_ready.
REQ-019 Push and pop in the same edge leave count unchanged; the FIFO never overflows, and a pop on empty is impossible.
REQ-020 States: RUN, FAULT. In RUN, if imem_address > MEM_SIZE-4 or imem_address[1:0] != 0 when an issue would occur, there is no issue, the state goes to FAULT, and fetch_fault is set to 1.
REQ-021 In FAULT there are no issues; already-buffered and in-flight entries still drain normally.
REQ-022 A redirect in any state flushes the FIFO (count<=0), squashes in-flight, sets imem_address<=redirect_pc, clears fetch_fault, and enters RUN; there is no issue on that edge.
REQ-023 Redirect wins over a same-edge push and pop: no push, and the pop is dropped; inst_valid is 0 the cycle after.
REQ-024 Latency: for a redirect at edge N, the issue is at N+1, the push at N+2, and inst_valid=1 after N+2.
REQ-025 Steady-state throughput is one instruction per cycle while inst_ready is held at 1.
REQ-026 Address arithmetic is 32-bit modulo; wrap-around past MEM_SIZE-4 faults per REQ-020 before any wrap.

Reset
REQ-027 While rst_n=0: imem_address=RESET_PC, state=RUN, count=0, inflight_valid=0, inst_valid=0, fetch_fault=0, and inst_data and inst_pc are 0 when the FIFO is empty.
REQ-028 The first issue occurs on the first posedge after rst_n rises; reset mid-stream discards all buffered and in-flight entries.

Configuration
REQ-029 With macro FETCH_PERF_EN defined, output fetch_count (32 bits) counts pops, resets to 0, is not cleared by redirect, and wraps at 2^32.
REQ-030 Without FETCH_PERF_EN, the port and counter are absent, and behaviour is otherwise identical.

Structure
REQ-031 Package ifetch_pkg holds the fetch entry typedef {pc[31:0], instr[31:0]}, the state enum {RUN, FAULT}, and the default RESET_PC and MEM_SIZE constants.
REQ-032 Sub-module fetch_fifo, parameterised on depth, has push, pop, flush, count, and head ports; instr_fetch holds only the PC, in-flight tracking and the FSM.

Verification
REQ-033 Reset with RESET_PC=0 and inst_ready=1: the bench sees inst_pc 0x0, 0x4, 0x8 on consecutive cycles starting 2 cycles after reset release, with inst_data matching the memory words.
REQ-034 Hold inst_ready=0 for 10 cycles: inst_valid stays 1 and count saturates at 4 with no further issues; on release, 4 buffered entries plus the refill arrive in order with no gap.
REQ-035 Redirect to 0x100 with 3 entries buffered and one in flight: the FIFO empties and the next inst_pc is 0x100, appearing exactly 2 edges later.
REQ-036 Fetch runs to 0x7FFC with MEM_SIZE=0x8000: the 0x7FFC entry is delivered, fetch_fault rises, and no 0x8000 entry is delivered; a redirect to 0x0 then clears the fault and fetch resumes.
REQ-037 Redirect to 0x102: fetch_fault=1 with no entries delivered.
REQ-038 With FETCH_PERF_EN defined, 7 handshakes give fetch_count=7; rst_n low mid-stream gives fetch_count=0, inst_valid=0, and imem_address=RESET_PC immediately.
